les_result_sink: RTL and testbench
==================================

# les_result_sink

Downstream capture stage for `les_top`. It watches `busy` for the falling edge that marks a finished encryption and captures the 32-bit `cipher_out`. Each captured word is folded into a 32-bit multiple-input signature register (MISR), and completed blocks are counted. On request, the signature is serialised onto a single pin, so a long LES soak run can be checked externally with one output, for example `DUMMYO`.

## Interface
Parameters:
- `DATA_W`, 32: cipher word width.
- `CNT_W`, 16: block counter width.
- `MISR_SEED`, 32'hACE1ACE1: signature value after reset or `clr`.
- `MISR_TAPS`, 32'h80200003: feedback tap mask (bits 31, 21, 1, 0).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `les_busy`  in  1  `busy` from `les_top`.
- `les_cipher`  in  DATA_W  `cipher_out` from `les_top`.
- `clr`  in  1  synchronous clear of the signature and the counter.
- `sig_req`  in  1  request a serial dump of the signature (level, sampled).
- `capture_pulse`  out  1  one-cycle strobe when a captured word is folded into the MISR.
- `block_count`  out  CNT_W  number of blocks folded; saturating.
- `signature`  out  DATA_W  current MISR value.
- `sig_bit`  out  1  serial signature bit, MSB first.
- `sig_valid`  out  1  high while `sig_bit` carries data.
- `sig_done`  out  1  one-cycle strobe after the last bit.

## Operation
- Reset (`resetn`=0 at an edge) sets the following values:
  - `busy_q`=0 and `cap_valid`=0.
  - `signature`=`MISR_SEED`.
  - `block_count`=0.
  - Serialiser state=IDLE.
  - All single-bit outputs=0.
- Edge detect: `busy_q` registers `les_busy`. A fall occurs when `busy_q`=1 and `les_busy`=0.
- On a fall: `cap_reg`<=`les_cipher`, `cap_valid`<=1. Otherwise `cap_valid`<=0.
- When `cap_valid`=1, the block performs a fold:
  - `fb` = XOR-reduce(`signature` & `MISR_TAPS`).
  - `signature` <= {`signature`[30:0], `fb`} ^ `cap_reg`.
  - `block_count` <= `block_count`+1, holding at all-ones.
  - `capture_pulse`=1 for that cycle.
- `clr`=1 sets `signature`=`MISR_SEED` and `block_count`=0, and drops any pending `cap_valid`.
  - `clr` wins over a simultaneous fold.
  - A fall in the same cycle as `clr` is discarded.
- Serialiser FSM (IDLE, SHIFT, DONE):
  - IDLE: if `sig_req`=1, snapshot `signature` into `shreg`, set bit index=DATA_W-1, and go to SHIFT.
  - SHIFT:
    - `sig_bit`=`shreg`[DATA_W-1] and `sig_valid`=1.
    - Each cycle, `shreg` shifts left.
    - After DATA_W cycles, go to DONE.
  - DONE: `sig_done`=1 for one cycle, then IDLE. `sig_req` is re-sampled only in IDLE, so a held `sig_req` restarts after one IDLE cycle.
- `sig_req` outside IDLE is ignored.
- Folds and `clr` during SHIFT do not alter the word being shifted (snapshot isolation).

## Timing
- Fall sampled at edge E: `cap_reg` is valid after E. The fold, `capture_pulse` and the counter increment take effect at E+1.
- Minimum spacing between folds: 2 cycles, since a fall needs `busy` high for at least one sampled cycle. No folds can be lost at this rate.
- `sig_req` sampled at edge R: first `sig_valid`/`sig_bit` (MSB) after R; last bit (LSB) after R+31; `sig_done` high after R+32; IDLE after R+33.
- A fold at edge R itself is not in the snapshot; the snapshot is the pre-edge `signature`.
- `les_busy` high at reset release produces no fall until it drops. `busy_q` starts at 0, so a low `busy` at reset produces no spurious fall.
- Reset mid-shift aborts the dump immediately: `sig_valid`=0 and no `sig_done`.
- All outputs are registered.

## Structure
- Shared package `les_pkg` holds:
  - `DATA_W`, `LES_MISR_SEED` and `LES_MISR_TAPS` constants.
  - The serialiser state enum {IDLE, SHIFT, DONE}.
- One sub-module: `les_sig_serializer`, covering the snapshot, shift register, bit counter and FSM, with ports `clk`/`resetn`/`req`/`word`/`bit`/`valid`/`done`.
- Edge detect, capture, MISR and counter stay in `les_result_sink`.

## Test plan
- Reset, then one `busy` pulse 1→0 with `les_cipher`=32'h00000001 → one `capture_pulse` 2 edges after the fall; `signature`=32'h59C359C2, `block_count`=1.
- Same stimulus with `les_cipher`=0 → `signature`=32'h59C359C3. A held `busy`=0 with no prior high → no fold.
- `clr` asserted in the same cycle as a busy fall → `signature`=32'hACE1ACE1, `block_count`=0, no `capture_pulse`.
- `sig_req` pulse after the first scenario → 32 cycles of `sig_valid`, with bits 0101_1001_1100_0011_0101_1001_1100_0010 MSB first, then a single `sig_done`. A second `sig_req` mid-shift is ignored.
- Fold during SHIFT → shifted word unchanged; `signature` updates; the next dump shows the new value. `resetn`=0 at bit 10 → `sig_valid` drops, no `sig_done`, `signature`=seed.
- Force `block_count` to all-ones (CNT_W=4 build, 16 folds) → stays 4'hF after the 16th fold while `signature` keeps updating.

Source files
------------

// File: rtl/les_pkg.sv
// ============================================================
// les_pkg : shared constants and serialiser state encoding
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

package les_pkg;

  localparam int          LES_DATA_W    = 32;
  localparam logic [31:0] LES_MISR_SEED = 32'hACE1ACE1;
  localparam logic [31:0] LES_MISR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_e;

endpackage

`default_nettype wire

// File: rtl/les_sig_serializer.sv
// ============================================================
// les_sig_serializer : snapshots a word and shifts it out MSB first
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module les_sig_serializer
  import les_pkg::*;
#(
  parameter int W = LES_DATA_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req,
  input  logic [W-1:0] word,
  output logic         ser_bit,
  output logic         valid,
  output logic         done
);

  localparam int IDX_W = $clog2(W);

  ser_state_e       state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bit_q, bit_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          shreg_d = word;
          idx_d   = IDX_W'(W - 1);
          state_d = SHIFT;
          valid_d = 1'b1;
        end
      end
      SHIFT: begin
        if (idx_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          // rotate rather than shift: the wrapped bit is never presented
          shreg_d = {shreg_q[W-2:0], shreg_q[W-1]};
          idx_d   = idx_q - 1'b1;
          valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bit_d = valid_d & shreg_d[W-1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ser_bit = bit_q;
  assign valid   = valid_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: rtl/les_result_sink.sv
// ============================================================
// les_result_sink : captures finished LES blocks into a MISR
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module les_result_sink #(
  parameter int                DATA_W    = les_pkg::LES_DATA_W,
  parameter int                CNT_W     = 16,
  parameter logic [DATA_W-1:0] MISR_SEED = les_pkg::LES_MISR_SEED,
  parameter logic [DATA_W-1:0] MISR_TAPS = les_pkg::LES_MISR_TAPS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              les_busy,
  input  logic [DATA_W-1:0] les_cipher,
  input  logic              clr,
  input  logic              sig_req,
  output logic              capture_pulse,
  output logic [CNT_W-1:0]  block_count,
  output logic [DATA_W-1:0] signature,
  output logic              sig_bit,
  output logic              sig_valid,
  output logic              sig_done
);

  import les_pkg::*;

  logic              busy_q, busy_d;
  logic [DATA_W-1:0] cap_reg_q, cap_reg_d;
  logic              cap_valid_q, cap_valid_d;
  logic [DATA_W-1:0] signature_q, signature_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pulse_q, pulse_d;
  logic              busy_fall;
  logic              fb;

  always_comb begin
    busy_fall   = busy_q & ~les_busy;
    fb          = ^(signature_q & MISR_TAPS);
    busy_d      = les_busy;
    cap_reg_d   = cap_reg_q;
    cap_valid_d = 1'b0;
    signature_d = signature_q;
    count_d     = count_q;
    pulse_d     = 1'b0;
    // clear discards both a pending fold and a fall seen on the same edge
    if (clr) begin
      signature_d = MISR_SEED;
      count_d     = '0;
    end else begin
      if (busy_fall) begin
        cap_reg_d   = les_cipher;
        cap_valid_d = 1'b1;
      end
      if (cap_valid_q) begin
        signature_d = {signature_q[DATA_W-2:0], fb} ^ cap_reg_q;
        pulse_d     = 1'b1;
        if (count_q != '1) begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q      <= 1'b0;
      cap_reg_q   <= '0;
      cap_valid_q <= 1'b0;
      signature_q <= MISR_SEED;
      count_q     <= '0;
      pulse_q     <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      cap_reg_q   <= cap_reg_d;
      cap_valid_q <= cap_valid_d;
      signature_q <= signature_d;
      count_q     <= count_d;
      pulse_q     <= pulse_d;
    end
  end

  les_sig_serializer #(
    .W (DATA_W)
  ) u_ser (
    .clk     (clk),
    .resetn  (resetn),
    .req     (sig_req),
    .word    (signature_q),
    .ser_bit (sig_bit),
    .valid   (sig_valid),
    .done    (sig_done)
  );

  assign capture_pulse = pulse_q;
  assign block_count   = count_q;
  assign signature     = signature_q;

endmodule

`default_nettype wire

// File: tb/tb_les_result_sink.sv
// ============================================================
// tb_les_result_sink : directed + random bench for les_result_sink
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module tb_les_result_sink;

  localparam logic [31:0] SEED = 32'hACE1ACE1;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        resetn;
  logic        les_busy;
  logic [31:0] les_cipher;
  logic        clr;
  logic        sig_req;

  logic        capture_pulse, sig_bit, sig_valid, sig_done;
  logic [15:0] block_count;
  logic [31:0] signature;

  logic        capture_pulse4, sig_bit4, sig_valid4, sig_done4;
  logic [3:0]  block_count4;
  logic [31:0] signature4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  les_result_sink dut (
    .clk(clk), .resetn(resetn), .les_busy(les_busy), .les_cipher(les_cipher),
    .clr(clr), .sig_req(sig_req), .capture_pulse(capture_pulse),
    .block_count(block_count), .signature(signature), .sig_bit(sig_bit),
    .sig_valid(sig_valid), .sig_done(sig_done)
  );

  les_result_sink #(.CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .les_busy(les_busy), .les_cipher(les_cipher),
    .clr(clr), .sig_req(sig_req), .capture_pulse(capture_pulse4),
    .block_count(block_count4), .signature(signature4), .sig_bit(sig_bit4),
    .sig_valid(sig_valid4), .sig_done(sig_done4)
  );

  // Reference model: cycle numbers, a queue of captured words, arithmetic on dump offsets
  int          cyc = 0;
  logic        m_prev_busy = 1'b0;
  logic [31:0] m_pend[$];
  logic [31:0] m_sig = SEED;
  int          m_total = 0;
  logic        m_pulse = 1'b0;
  int          m_req_cyc = -1;
  logic [31:0] m_snap = '0;

  function automatic logic [31:0] misr_fold(input logic [31:0] s, input logic [31:0] w);
    logic f;
    f = 1'b0;
    for (int i = 0; i < 32; i++) if (TAPS[i]) f ^= s[i];
    return {s[30:0], f} ^ w;
  endfunction

  task automatic model_step();
    logic fall;
    cyc++;
    if (!resetn) begin
      m_prev_busy = 1'b0;
      m_pend.delete();
      m_sig     = SEED;
      m_total   = 0;
      m_pulse   = 1'b0;
      m_req_cyc = -1;
      return;
    end
    if (sig_req && (m_req_cyc < 0 || cyc >= m_req_cyc + 34)) begin
      m_req_cyc = cyc;
      m_snap    = m_sig;
    end
    fall        = m_prev_busy && !les_busy;
    m_prev_busy = les_busy;
    m_pulse     = 1'b0;
    if (clr) begin
      m_sig   = SEED;
      m_total = 0;
      m_pend.delete();
    end else begin
      if (m_pend.size() > 0) begin
        m_sig = misr_fold(m_sig, m_pend.pop_front());
        m_total++;
        m_pulse = 1'b1;
      end
      if (fall) m_pend.push_back(les_cipher);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    int   j;
    logic e_valid, e_bit, e_done;
    e_valid = 1'b0; e_bit = 1'b0; e_done = 1'b0;
    if (m_req_cyc >= 0) begin
      j       = cyc - m_req_cyc;
      e_valid = (j <= 31);
      e_bit   = e_valid ? m_snap[31-j] : 1'b0;
      e_done  = (j == 32);
    end
    chk("capture_pulse", 32'(capture_pulse), 32'(m_pulse));
    chk("signature", signature, m_sig);
    chk("block_count", 32'(block_count), 32'((m_total > 65535) ? 65535 : m_total));
    chk("block_count4", 32'(block_count4), 32'((m_total > 15) ? 15 : m_total));
    chk("signature4", signature4, m_sig);
    chk("sig_valid", 32'(sig_valid), 32'(e_valid));
    chk("sig_bit", 32'(sig_bit), 32'(e_bit));
    chk("sig_done", 32'(sig_done), 32'(e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic fall_word(input logic [31:0] w);
    les_busy = 1'b1; tick();
    les_busy = 1'b0; les_cipher = w; tick();
  endtask

  int          nvalid, ndone;
  logic [31:0] got_word;

  initial begin
    resetn = 1'b0; les_busy = 1'b0; les_cipher = '0; clr = 1'b0; sig_req = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("reset_signature", signature, SEED);

    // single fold of word 1
    fall_word(32'h00000001);
    tick();
    chk("fold1_signature", signature, 32'h59C359C2);
    chk("fold1_count", 32'(block_count), 32'd1);

    // serial dump with a second request mid-shift
    sig_req = 1'b1; tick(); sig_req = 1'b0;
    nvalid = 0; ndone = 0; got_word = '0;
    for (int i = 0; i < 40; i++) begin
      if (sig_valid) begin got_word = {got_word[30:0], sig_bit}; nvalid++; end
      if (sig_done) ndone++;
      sig_req = (i == 10);
      tick();
    end
    sig_req = 1'b0;
    chk("dump_word", got_word, 32'h59C359C2);
    chk("dump_valid_cycles", 32'(nvalid), 32'd32);
    chk("dump_done_count", 32'(ndone), 32'd1);

    // clr coincident with a fall
    les_busy = 1'b1; tick();
    les_busy = 1'b0; les_cipher = 32'hDEADBEEF; clr = 1'b1; tick();
    clr = 1'b0; tick(); tick();
    chk("clr_signature", signature, SEED);
    chk("clr_count", 32'(block_count), 32'd0);

    // fold of zero, then busy held low
    fall_word(32'h00000000);
    tick();
    chk("fold0_signature", signature, 32'h59C359C3);
    for (int i = 0; i < 5; i++) tick();
    chk("idle_count", 32'(block_count), 32'd1);

    // fold during a shift, then redump
    sig_req = 1'b1; tick(); sig_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    fall_word($urandom);
    for (int i = 0; i < 30; i++) tick();
    sig_req = 1'b1; tick(); sig_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // reset in the middle of a dump
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("abort_valid", 32'(sig_valid), 32'd0);
    for (int i = 0; i < 30; i++) tick();
    chk("abort_signature", signature, SEED);

    // saturation of the narrow counter
    for (int i = 0; i < 17; i++) fall_word($urandom);
    tick();
    chk("sat_count4", 32'(block_count4), 32'hF);
    chk("sat_count16", 32'(block_count), 32'd17);

    // randomized soak
    for (int i = 0; i < 3000; i++) begin
      les_busy   = ($urandom_range(0, 2) != 0);
      les_cipher = $urandom;
      clr        = ($urandom_range(0, 39) == 0);
      sig_req    = ($urandom_range(0, 19) == 0);
      resetn     = ($urandom_range(0, 299) != 0);
      tick();
    end
    resetn = 1'b1; clr = 1'b0; sig_req = 1'b0; les_busy = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
